// File: rtl/generador_paquetes_param.sv
// Parametrised symbol-stream generator: COM, then per packet STP/payload/END,
// IDL gaps between packets and periodic SKP insertion, on a valid/ready output.
//
// state | meaning
// IDLE  | no burst, valid low, waiting for start
// COM   | presenting the burst-opening COM symbol
// STP   | presenting a packet start symbol
// PAY   | presenting a payload byte
// END   | presenting a packet end symbol
// GAP   | presenting an inter-packet IDL symbol
// SKP   | presenting an inserted SKP; pend_q holds the symbol it deferred
module generador_paquetes_param #(
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned GAP_LEN      = 2,
  parameter int unsigned SKP_INTERVAL = 16,
  parameter int unsigned PAYLOAD_MODE = 0,
  parameter logic [7:0]  SEED         = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [7:0]       num_pkts,
  input  logic             ready_in,
  output logic             valid,
  output logic [7:0]       data,
  output logic             k_flag,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COM  = 3'd1;
  localparam logic [2:0] S_STP  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [2:0] S_SKP  = 3'd6;

  localparam logic [7:0] K_COM = 8'hbc;
  localparam logic [7:0] K_SKP = 8'h1c;
  localparam logic [7:0] K_STP = 8'hfb;
  localparam logic [7:0] K_END = 8'hfd;
  localparam logic [7:0] K_IDL = 8'h7c;

  localparam int CNT_W = $clog2(SKP_INTERVAL + 1);
  localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

  localparam logic [CNT_W-1:0] SKP_SAT  = CNT_W'(SKP_INTERVAL);
  // The slot about to be filled counts toward the interval, so the SKP goes
  // out once SKP_INTERVAL-1 symbols have been accepted since the last one.
  localparam logic [CNT_W-1:0] SKP_TRIG = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LEN);

  logic [2:0]       state_q, state_d;
  logic [2:0]       pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gen_q, gen_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pay_q, pay_d;
  logic [7:0]       pkts_q, pkts_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       nxt;
  logic             emit;
  logic             last;

  function automatic logic [7:0] ctrl_code(input logic [2:0] s);
    case (s)
      S_COM:   ctrl_code = K_COM;
      S_STP:   ctrl_code = K_STP;
      S_END:   ctrl_code = K_END;
      S_GAP:   ctrl_code = K_IDL;
      S_SKP:   ctrl_code = K_SKP;
      default: ctrl_code = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gen_step(input logic [7:0] g);
    if (PAYLOAD_MODE == 0) gen_step = g + 8'd1;
    else                   gen_step = {g[6:0], g[7] ^ g[5] ^ g[4] ^ g[3]};
  endfunction

  assign xfer = valid_q && ready_in;

  // SKP spacing counter value after the current transfer
  always_comb begin
    if (state_q == S_SKP)     cnt_inc = '0;
    else if (cnt_q < SKP_SAT) cnt_inc = cnt_q + CNT_W'(1);
    else                      cnt_inc = cnt_q;
  end

  // Next-symbol selection, advanced only on an accepted transfer
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    data_d  = data_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    gen_d   = gen_q;
    len_d   = len_q;
    pay_d   = pay_q;
    pkts_d  = pkts_q;
    gap_d   = gap_q;
    nxt     = state_q;
    emit    = 1'b0;
    last    = 1'b0;

    if (state_q == S_IDLE) begin
      if (start && (pkt_len != '0) && (num_pkts != 8'd0)) begin
        len_d  = pkt_len;
        pkts_d = num_pkts;
        gen_d  = SEED;
        busy_d = 1'b1;
        nxt    = S_COM;
        emit   = 1'b1;
      end
    end else if (xfer) begin
      cnt_d = cnt_inc;
      emit  = 1'b1;
      case (state_q)
        S_COM: nxt = S_STP;
        S_STP: begin
          nxt   = S_PAY;
          pay_d = len_q;
        end
        S_PAY: begin
          pay_d = pay_q - LEN_W'(1);
          nxt   = (pay_q == LEN_W'(1)) ? S_END : S_PAY;
        end
        S_END: begin
          if (pkts_q == 8'd1) begin
            last = 1'b1;
          end else begin
            pkts_d = pkts_q - 8'd1;
            if (GAP_LEN == 0) begin
              nxt = S_STP;
            end else begin
              gap_d = GAP_INIT;
              nxt   = S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_d = gap_q - GAP_W'(1);
          nxt   = (gap_q == GAP_W'(1)) ? S_STP : S_GAP;
        end
        S_SKP:   nxt = pend_q;
        default: last = 1'b1;
      endcase
      if (((nxt == S_STP) || (nxt == S_GAP)) && (cnt_inc >= SKP_TRIG)) begin
        pend_d = nxt;
        nxt    = S_SKP;
      end
    end

    if (last) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      data_d  = 8'h00;
      k_d     = 1'b0;
    end else if (emit) begin
      state_d = nxt;
      valid_d = 1'b1;
      if (nxt == S_PAY) begin
        data_d = gen_q;
        k_d    = 1'b0;
        gen_d  = gen_step(gen_q);
      end else begin
        data_d = ctrl_code(nxt);
        k_d    = 1'b1;
      end
    end
  end

  // State and output registers; reset abandons any burst at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= S_STP;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gen_q   <= SEED;
      len_q   <= '0;
      pay_q   <= '0;
      pkts_q  <= 8'd0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      gen_q   <= gen_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      pkts_q  <= pkts_d;
      gap_q   <= gap_d;
    end
  end

  assign valid  = valid_q;
  assign data   = data_q;
  assign k_flag = k_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_generador_paquetes_param.sv
// Bench for generador_paquetes_param: two instances (incrementing payload with
// gaps, LFSR payload without gaps) driven together and compared per symbol
// against a burst-level reference model.
module tb_generador_paquetes_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pkt_len = 8'd0;
  logic [7:0] num_pkts = 8'd0;
  logic       ready_in = 1'b0;

  logic       v0, k0, b0, dn0;
  logic [7:0] d0;
  logic       v1, k1, b1, dn1;
  logic [7:0] d1;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  logic [8:0] log0[$];
  logic [8:0] log1[$];
  int mcnt0 = 0;
  int mcnt1 = 0;
  int fcyc0, lcyc0;

  always #5 clk = ~clk;

  generador_paquetes_param #(
    .LEN_W(8), .GAP_LEN(2), .SKP_INTERVAL(8), .PAYLOAD_MODE(0), .SEED(8'h01)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .ready_in(ready_in), .valid(v0), .data(d0), .k_flag(k0), .busy(b0), .done(dn0)
  );

  generador_paquetes_param #(
    .LEN_W(8), .GAP_LEN(0), .SKP_INTERVAL(4), .PAYLOAD_MODE(1), .SEED(8'h01)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .ready_in(ready_in), .valid(v1), .data(d1), .k_flag(k1), .busy(b1), .done(dn1)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Expected accepted-symbol list {k,data} for one burst of instance u
  task automatic build_model(input int u, input int len, input int n);
    logic [8:0] raw[$];
    logic [8:0] q[$];
    int cnt, gap, intv, mode;
    logic [7:0] v;
    if (u == 0) begin mode = 0; gap = 2; intv = 8; cnt = mcnt0; end
    else        begin mode = 1; gap = 0; intv = 4; cnt = mcnt1; end
    v = 8'h01;
    raw.push_back(9'h1bc);
    for (int p = 0; p < n; p++) begin
      raw.push_back(9'h1fb);
      for (int i = 0; i < len; i++) begin
        raw.push_back({1'b0, v});
        v = (mode == 0) ? v + 8'd1 : lfsr_next(v);
      end
      raw.push_back(9'h1fd);
      if (p < n - 1) for (int g = 0; g < gap; g++) raw.push_back(9'h17c);
    end
    foreach (raw[i]) begin
      if ((raw[i] == 9'h1fb || raw[i] == 9'h17c) && cnt + 1 >= intv) begin
        q.push_back(9'h11c);
        cnt = 0;
      end
      q.push_back(raw[i]);
      cnt = (cnt + 1 > intv) ? intv : cnt + 1;
    end
    if (u == 0) begin exp0 = q; mcnt0 = cnt; end
    else        begin exp1 = q; mcnt1 = cnt; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    ready_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mcnt0 = 0;
    mcnt1 = 0;
  endtask

  // Launch one burst on both instances and check every cycle until both finish.
  // rmode: 0 ready always, 1 alternating, 2 random. poke: pulse start mid-burst.
  task automatic run_burst(input int len, input int n, input int rmode, input bit poke);
    bit sp[2];
    bit ds[2];
    logic [8:0] hv[2];
    logic cv, cb, cdn;
    logic [8:0] cd, want;
    int cyc;
    build_model(0, len, n);
    build_model(1, len, n);
    log0.delete();
    log1.delete();
    fcyc0 = -1;
    lcyc0 = -1;
    sp = '{0, 0};
    ds = '{0, 0};
    @(negedge clk);
    pkt_len = 8'(len);
    num_pkts = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(ds[0] && ds[1]) && cyc < 2000) begin
      case (rmode)
        0:       ready_in = 1'b1;
        1:       ready_in = (cyc % 2 == 0);
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc >= 1 && cyc <= 3) begin
        start = 1'b1;
        pkt_len = 8'($urandom_range(1, 255));
        num_pkts = 8'($urandom_range(1, 255));
      end else if (poke && cyc == 4) begin
        start = 1'b0;
      end
      for (int u = 0; u < 2; u++) begin
        if (u == 0) begin cv = v0; cd = {k0, d0}; cb = b0; cdn = dn0; end
        else        begin cv = v1; cd = {k1, d1}; cb = b1; cdn = dn1; end
        if (sp[u]) begin
          checks++;
          if (cv !== 1'b1 || cd !== hv[u]) begin
            errors++;
            $display("FAIL stall_hold u%0d cyc %0d: got v=%b %h, want v=1 %h", u, cyc, cv, cd, hv[u]);
          end
        end
        if (!ds[u] && !cdn) begin
          checks++;
          if (cb !== 1'b1) begin
            errors++;
            $display("FAIL busy u%0d cyc %0d: got %b, want 1", u, cyc, cb);
          end
        end
        if (cv === 1'b1 && ready_in) begin
          checks++;
          if (u == 0) begin
            want = (exp0.size() > 0) ? exp0.pop_front() : 9'h0xx;
            log0.push_back(cd);
            if (fcyc0 < 0) fcyc0 = cyc;
            lcyc0 = cyc;
          end else begin
            want = (exp1.size() > 0) ? exp1.pop_front() : 9'h0xx;
            log1.push_back(cd);
          end
          if (cd !== want) begin
            errors++;
            $display("FAIL symbol u%0d cyc %0d: got k,data=%h, want %h", u, cyc, cd, want);
          end
        end
        sp[u] = (cv === 1'b1) && !ready_in;
        hv[u] = cd;
        if (cdn === 1'b1) begin
          checks++;
          if (ds[u] || cv !== 1'b0 || cb !== 1'b0 ||
              (u == 0 ? exp0.size() : exp1.size()) != 0) begin
            errors++;
            $display("FAIL done u%0d cyc %0d: got done=1 (seen=%0d v=%b busy=%b left=%0d), want single pulse after last END",
                     u, cyc, ds[u], cv, cb, (u == 0 ? exp0.size() : exp1.size()));
          end
          ds[u] = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!(ds[0] && ds[1])) begin
      errors++;
      $display("FAIL burst_timeout: got done0=%0d done1=%0d, want both within 2000 cycles", ds[0], ds[1]);
    end
    checks++;
    if (dn0 !== 1'b0 || dn1 !== 1'b0 || v0 !== 1'b0 || v1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: got done=%b%b valid=%b%b, want 00 00", dn0, dn1, v0, v1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({v0, d0, k0, b0, dn0} !== 12'h0 || {v1, d1, k1, b1, dn1} !== 12'h0) begin
      errors++;
      $display("FAIL reset_state: got %b %h %b %b %b / %b %h %b %b %b, want all zero",
               v0, d0, k0, b0, dn0, v1, d1, k1, b1, dn1);
    end
    reset = 1'b0;
    @(negedge clk);
    pkt_len = 8'd5;
    num_pkts = 8'd2;
    ready_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (b0 !== 1'b1 || b1 !== 1'b1) begin
      errors++;
      $display("FAIL midburst_busy: got %b%b, want 11", b0, b1);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (v0 !== 1'b0 || b0 !== 1'b0 || v1 !== 1'b0 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: got valid=%b%b busy=%b%b, want 00 00", v0, v1, b0, b1);
    end
    @(negedge clk);
    reset = 1'b0;
    mcnt0 = 0;
    mcnt1 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (dn0 !== 1'b0 || dn1 !== 1'b0 || v0 !== 1'b0 || v1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done cyc %0d: got done=%b%b valid=%b%b, want 00 00", i, dn0, dn1, v0, v1);
      end
    end
    run_burst(2, 1, 0, 0);
  endtask

  task automatic test_single_packet();
    logic [8:0] t2[6];
    t2 = '{9'h1bc, 9'h1fb, 9'h001, 9'h002, 9'h003, 9'h1fd};
    do_reset();
    run_burst(3, 1, 0, 0);
    checks++;
    if (fcyc0 != 0 || lcyc0 != 5) begin
      errors++;
      $display("FAIL single_timing: got first=%0d last=%0d, want 0 and 5", fcyc0, lcyc0);
    end
    checks++;
    if (log0.size() != 6) begin
      errors++;
      $display("FAIL single_count: got %0d, want 6", log0.size());
    end else begin
      foreach (t2[i]) begin
        checks++;
        if (log0[i] !== t2[i]) begin
          errors++;
          $display("FAIL single_sym %0d: got %h, want %h", i, log0[i], t2[i]);
        end
      end
    end
  endtask

  task automatic test_multi_packet_skp();
    logic [8:0] t3[18];
    t3 = '{9'h1bc, 9'h1fb, 9'h001, 9'h002, 9'h1fd, 9'h17c, 9'h17c, 9'h11c, 9'h1fb,
           9'h003, 9'h004, 9'h1fd, 9'h17c, 9'h17c, 9'h1fb, 9'h005, 9'h006, 9'h1fd};
    do_reset();
    run_burst(2, 3, 0, 0);
    checks++;
    if (log0.size() != 18) begin
      errors++;
      $display("FAIL multi_count: got %0d, want 18", log0.size());
    end else begin
      foreach (t3[i]) begin
        checks++;
        if (log0[i] !== t3[i]) begin
          errors++;
          $display("FAIL multi_sym %0d: got %h, want %h", i, log0[i], t3[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] t2[6];
    t2 = '{9'h1bc, 9'h1fb, 9'h001, 9'h002, 9'h003, 9'h1fd};
    do_reset();
    run_burst(3, 1, 1, 0);
    checks++;
    if (log0.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d, want 6", log0.size());
    end else begin
      foreach (t2[i]) begin
        checks++;
        if (log0[i] !== t2[i]) begin
          errors++;
          $display("FAIL bp_sym %0d: got %h, want %h", i, log0[i], t2[i]);
        end
      end
    end
    run_burst(3, 1, 2, 0);
    run_burst(2, 3, 2, 0);
  endtask

  task automatic test_lfsr_busy_start();
    logic [8:0] t5[7];
    t5 = '{9'h1bc, 9'h1fb, 9'h001, 9'h002, 9'h004, 9'h008, 9'h1fd};
    do_reset();
    run_burst(4, 1, 0, 1);
    checks++;
    if (log1.size() != 7) begin
      errors++;
      $display("FAIL lfsr_count: got %0d, want 7", log1.size());
    end else begin
      foreach (t5[i]) begin
        checks++;
        if (log1[i] !== t5[i]) begin
          errors++;
          $display("FAIL lfsr_sym %0d: got %h, want %h", i, log1[i], t5[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      pkt_len = (t == 0) ? 8'd0 : 8'd3;
      num_pkts = (t == 0) ? 8'd3 : 8'd0;
      ready_in = 1'b1;
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if ({v0, b0, dn0, v1, b1, dn1} !== 6'b0) begin
          errors++;
          $display("FAIL zero_len t%0d cyc %0d: got v,b,done=%b%b%b %b%b%b, want 000 000",
                   t, i, v0, b0, dn0, v1, b1, dn1);
        end
      end
      start = 1'b0;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_burst($urandom_range(1, 6), $urandom_range(1, 4), 2, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_multi_packet_skp();
    test_backpressure();
    test_lfsr_busy_start();
    test_zero_len();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
